router_port: RTL
================

# router_port

Router-side endpoint of the node-to-router byte-serial link, one instance per router port. It receives 4-byte packets that a node streams MSB-first on `put_outbound`/`payload_outbound`, reassembles them, and queues them for the router core. It also takes 32-bit packets from the router core and streams them MSB-first to the node on `put_inbound`/`payload_inbound`, honouring the node's `free_inbound`.

## Interface
- `DEPTH`, default 2: receive queue depth in packets; power of two, ≥2.
- `clock`  in  1  sole clock; all logic is clocked on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `free_outbound`  out  1  to node: port can accept a new packet.
- `put_outbound`  in  1  from node: byte valid this cycle.
- `payload_outbound`  in  8  from node: serial byte.
- `rx_pkt`  out  32  head-of-queue packet to router core (show-ahead).
- `rx_valid`  out  1  queue non-empty.
- `rx_ready`  in  1  core pops head when `rx_valid & rx_ready`.
- `rx_err`  out  1  one-cycle pulse on a link protocol violation.
- `tx_pkt`  in  32  packet from router core.
- `tx_valid`  in  1  `tx_pkt` valid.
- `tx_ready`  out  1  port accepts `tx_pkt` when `tx_valid & tx_ready`.
- `free_inbound`  in  1  from node: node can receive.
- `put_inbound`  out  1  to node: byte valid.
- `payload_inbound`  out  8  to node: serial byte.

## Operation
- Byte order on both directions: byte 0 = `[31:24]`, byte 1 = `[23:16]`, byte 2 = `[15:8]`, byte 3 = `[7:0]`. A packet is exactly 4 consecutive `put` cycles.
- RX FSM states:
  - `RX_IDLE`:
    - `put_outbound` with `free_outbound` = 1: capture byte 0, go to `RX_BUSY` with byte count 1.
    - `put_outbound` with `free_outbound` = 0: pulse `rx_err`, go to `RX_DROP`.
  - `RX_BUSY`:
    - `put_outbound` = 1: capture the next byte. On the 4th byte, push the assembled packet into the queue and go to `RX_IDLE`.
    - `put_outbound` = 0 before the 4th byte: discard the partial packet, pulse `rx_err`, go to `RX_IDLE`.
  - `RX_DROP`: ignore bytes; go to `RX_IDLE` on the first cycle with `put_outbound` = 0.
- `free_outbound` = (`RX_IDLE`) & (count < `DEPTH`). It is decoded from registers only and never from `put_outbound`. The in-flight packet thus holds a reserved slot, so the queue never overflows.
- Queue: circular buffer with read/write pointers modulo `DEPTH` and count 0..`DEPTH`. A push and a pop in the same cycle leave the count unchanged. A pop with `rx_valid` = 0 is ignored.
- TX FSM states:
  - `TX_IDLE`: `tx_ready` = 1. On a handshake, latch `tx_pkt` into the holding register and go to `TX_WAIT`.
  - `TX_WAIT`: when `free_inbound` = 1, go to `TX_SEND` with byte index 0.
  - `TX_SEND`: `put_inbound` = 1 and `payload_inbound` = byte[index]. After index 3, go to `TX_GAP`.
  - `TX_GAP`: one cycle with `put_inbound` = 0 (node drains), then go to `TX_IDLE`.
- `payload_inbound` = 8'h00 whenever `put_inbound` = 0.
- RX and TX are fully independent; simultaneous activity on both is legal.

## Timing
- Reset: any cycle with `reset` high sets the next state to:
  - RX = `RX_IDLE`, TX = `TX_IDLE`, queue empty, pointers 0.
  - `put_inbound` = 0, `payload_inbound` = 0, `rx_err` = 0, `rx_valid` = 0.
- While `reset` is high, `free_outbound` and `tx_ready` are forced to 0. Reset mid-packet aborts both directions with no `rx_err`.
- RX latency: bytes on cycles N..N+3 give `rx_valid` = 1 with the packet at cycle N+4. `free_outbound` is low on N+1..N+3 and re-evaluates on N+4.
- TX latency: handshake at cycle T with `free_inbound` = 1 at T+1 gives `put_inbound` high on T+2..T+5 and `tx_ready` high again at T+7. If `free_inbound` is low at T+1, the first byte is delayed until the cycle after `free_inbound` is sampled high.
- `put_inbound`, `payload_inbound` and `rx_err` are registered outputs.

## Test plan
- Single RX: node sends 8'hDE,8'hAD,8'hBE,8'hEF on cycles 1..4 -> `rx_pkt` = 32'hDEADBEEF with `rx_valid` = 1 at cycle 5; `free_outbound` low on 2..4.
- Queue full: with `DEPTH` = 2, receive 2 packets and hold `rx_ready` = 0 -> `free_outbound` = 0. One pop -> `free_outbound` = 1 the next cycle. Order is preserved (FIFO).
- Violation: `put_outbound` while full -> single `rx_err` pulse, bytes dropped, count unchanged. A 2-byte burst -> `rx_err` pulse, no push.
- Single TX: `tx_pkt` = 32'h01234567 accepted at cycle 0 with `free_inbound` = 1 -> `payload_inbound` = 01,23,45,67 on cycles 2..5 with `put_inbound` high, then one low cycle, then `tx_ready` at 7.
- Backpressure TX: `free_inbound` held low for 10 cycles -> `put_inbound` stays 0 and `tx_ready` stays 0; send starts the cycle after release.
- Loopback and reset: connect a reference `Node` on both sides and stream 20 random packets both ways -> all received intact. Asserting `reset` mid-transfer -> all outputs reach their reset values the next cycle.

Source files
------------

// File: rtl/router_port.sv
// Router-side endpoint of the node byte-serial link: reassembles 4-byte RX
// packets into a show-ahead queue and serialises 32-bit TX packets MSB-first.
module router_port #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        free_outbound,
  input  logic        put_outbound,
  input  logic [7:0]  payload_outbound,
  output logic [31:0] rx_pkt,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_err,
  input  logic [31:0] tx_pkt,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        free_inbound,
  output logic        put_inbound,
  output logic [7:0]  payload_inbound
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RX_IDLE, RX_BUSY, RX_DROP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SEND, TX_GAP} tx_state_t;

  rx_state_t      rx_state, rx_state_n;
  logic [1:0]     rx_cnt, rx_cnt_n;
  logic [23:0]    rx_shift, rx_shift_n;
  logic           push, pop, err_n;
  logic [31:0]    mem [DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [CW-1:0]  count;

  assign rx_valid      = (count != '0);
  assign rx_pkt        = mem[rptr];
  assign pop           = rx_valid & rx_ready;
  // Decoded from registers only: a started packet already owns its slot.
  assign free_outbound = ~reset & (rx_state == RX_IDLE) & (count < CW'(DEPTH));

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_shift_n = rx_shift;
    push       = 1'b0;
    err_n      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (put_outbound) begin
          if (free_outbound) begin
            rx_state_n = RX_BUSY;
            rx_cnt_n   = 2'd1;
            rx_shift_n = {rx_shift[15:0], payload_outbound};
          end else begin
            err_n      = 1'b1;
            rx_state_n = RX_DROP;
          end
        end
      end
      RX_BUSY: begin
        if (put_outbound) begin
          if (rx_cnt == 2'd3) begin
            push       = 1'b1;
            rx_state_n = RX_IDLE;
            rx_cnt_n   = 2'd0;
          end else begin
            rx_shift_n = {rx_shift[15:0], payload_outbound};
            rx_cnt_n   = rx_cnt + 2'd1;
          end
        end else begin
          err_n      = 1'b1;
          rx_state_n = RX_IDLE;
          rx_cnt_n   = 2'd0;
        end
      end
      RX_DROP: begin
        if (!put_outbound) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= 2'd0;
      rx_shift <= '0;
      rx_err   <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_shift <= rx_shift_n;
      rx_err   <= err_n;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) mem[wptr] <= {rx_shift, payload_outbound};
  end

  tx_state_t   tx_state, tx_state_n;
  logic [1:0]  tx_idx, tx_idx_n;
  logic [31:0] hold, hold_n;
  logic [7:0]  tx_byte;

  assign tx_ready = ~reset & (tx_state == TX_IDLE);

  always_comb begin
    tx_state_n = tx_state;
    tx_idx_n   = tx_idx;
    hold_n     = hold;
    case (tx_state)
      TX_IDLE: begin
        if (tx_valid && tx_ready) begin
          hold_n     = tx_pkt;
          tx_state_n = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (free_inbound) begin
          tx_state_n = TX_SEND;
          tx_idx_n   = 2'd0;
        end
      end
      TX_SEND: begin
        if (tx_idx == 2'd3) tx_state_n = TX_GAP;
        else                tx_idx_n   = tx_idx + 2'd1;
      end
      TX_GAP:  tx_state_n = TX_IDLE;
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so the byte lines
  // change exactly on the edge that enters/advances TX_SEND.
  always_comb begin
    tx_byte = 8'h00;
    case (tx_idx_n)
      2'd0: tx_byte = hold_n[31:24];
      2'd1: tx_byte = hold_n[23:16];
      2'd2: tx_byte = hold_n[15:8];
      2'd3: tx_byte = hold_n[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state        <= TX_IDLE;
      tx_idx          <= 2'd0;
      hold            <= '0;
      put_inbound     <= 1'b0;
      payload_inbound <= 8'h00;
    end else begin
      tx_state        <= tx_state_n;
      tx_idx          <= tx_idx_n;
      hold            <= hold_n;
      put_inbound     <= (tx_state_n == TX_SEND);
      payload_inbound <= (tx_state_n == TX_SEND) ? tx_byte : 8'h00;
    end
  end

endmodule
